// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared definitions for the execute-stage divider.
//   - funct3 codes for the RV32M divide group
//   - zero constants for data words and register addresses
//   - divider FSM state encoding
//   - hold level that control uses for an execute-stage hold
//   - two's-complement helper used for the signed operand/result fix-up
package ex_div_pkg;

  localparam int DataW = 32;
  localparam int RegW  = 5;

  // funct3 encodings of the divide group
  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  localparam logic [DataW-1:0] ZeroWord = '0;
  localparam logic [RegW-1:0]  ZeroReg  = '0;

  // Hold level the control block applies when the execute stage stalls
  localparam logic [2:0] HoldEx = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_CALC  = 2'b10,
    S_END   = 2'b11
  } div_state_e;

  function automatic logic [DataW-1:0] twos_neg(input logic [DataW-1:0] v);
    return (~v) + DataW'(1);
  endfunction

endpackage

// File: rtl/ex_div_step.sv
// ex_div_step: one combinational restoring-division step.
//   rem_i     : partial remainder before this step (always < divisor_i)
//   bit_i     : next dividend bit shifted into the partial remainder
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after compare/subtract
//   q_bit_o   : quotient bit produced by this step
module ex_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_bit_o
);

  logic [W:0] partial;
  logic [W:0] diff;

  // The partial remainder can reach 2*divisor-1, so compare in W+1 bits.
  // Either result then fits back into W bits.
  assign partial = {rem_i, bit_i};
  assign diff    = partial - {1'b0, divisor_i};
  assign q_bit_o = (partial >= {1'b0, divisor_i});
  assign rem_o   = q_bit_o ? diff[W-1:0] : partial[W-1:0];

endmodule

// File: rtl/ex_div.sv
// ex_div: iterative restoring divider for RV32M DIV/DIVU/REM/REMU.
//   clk, rst         : clock, asynchronous active-low reset
//   dividend_i       : rs1 value from ID/EX
//   divisor_i        : rs2 value from ID/EX
//   op_i             : funct3 selecting DIV/DIVU/REM/REMU
//   start_i          : one-cycle request from the execute decoder
//   reg_waddr_i      : destination register
//   abort_i          : flush; cancels the operation in flight
//   result_o         : quotient or remainder, held between operations
//   ready_o          : one-cycle pulse when result_o/reg_waddr_o are valid
//   reg_waddr_o      : destination register captured with the request
//   busy_o           : high whenever the FSM is not idle
//   hold_req_o       : pipeline hold request to control
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [2:0]        op_i,
  input  logic              start_i,
  input  logic [RegW-1:0]   reg_waddr_i,
  input  logic              abort_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ready_o,
  output logic [RegW-1:0]   reg_waddr_o,
  output logic              busy_o,
  output logic              hold_req_o
);

  localparam int CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] dividend_q, divisor_q, quot_q, rem_q, result_q;
  logic [2:0]        op_q;
  logic [RegW-1:0]   waddr_q, waddr_out_q;
  logic [CntW-1:0]   count_q;
  logic              neg_quot_q, neg_rem_q, busy_q;

  logic              op_signed, op_rem, div_zero, enter_end;
  logic [DATA_W-1:0] step_rem, quot_fin, quot_signed, rem_signed;
  logic              step_q_bit;

  assign op_signed = (op_q == INST_DIV) || (op_q == INST_REM);
  assign op_rem    = (op_q == INST_REM) || (op_q == INST_REMU);
  assign div_zero  = (divisor_q == ZeroWord);
  assign enter_end = (state_d == S_END) && (state_q != S_END);

  ex_div_step #(.W(DATA_W)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dividend_q[DATA_W-1]),
    .divisor_i (divisor_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q_bit)
  );

  // Final quotient includes the bit produced by the last CALC step, so the
  // signed result is ready on the same edge that enters END.
  assign quot_fin    = {quot_q[DATA_W-2:0], step_q_bit};
  assign quot_signed = neg_quot_q ? twos_neg(quot_fin) : quot_fin;
  assign rem_signed  = neg_rem_q  ? twos_neg(step_rem) : step_rem;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort wins over every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i && !abort_i) state_d = S_START;
      S_START: if (abort_i)             state_d = S_IDLE;
               else if (div_zero)       state_d = S_END;
               else                     state_d = S_CALC;
      S_CALC:  if (abort_i)             state_d = S_IDLE;
               else if (count_q == LastCnt) state_d = S_END;
      S_END:                            state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Outputs; ready is gated so a flush in END drops the write-back
  always_comb begin
    ready_o    = (state_q == S_END) && !abort_i;
    hold_req_o = ((state_q == S_IDLE) && start_i && !abort_i) ||
                 (state_q == S_START) || (state_q == S_CALC);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dividend_q  <= ZeroWord;
      divisor_q   <= ZeroWord;
      quot_q      <= ZeroWord;
      rem_q       <= ZeroWord;
      result_q    <= ZeroWord;
      op_q        <= 3'b000;
      waddr_q     <= ZeroReg;
      waddr_out_q <= ZeroReg;
      count_q     <= '0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      case (state_q)
        S_IDLE: if (start_i && !abort_i) begin
          dividend_q <= dividend_i;
          divisor_q  <= divisor_i;
          op_q       <= op_i;
          waddr_q    <= reg_waddr_i;
        end
        S_START: if (!div_zero) begin
          dividend_q <= (op_signed && dividend_q[DATA_W-1]) ? twos_neg(dividend_q) : dividend_q;
          divisor_q  <= (op_signed && divisor_q[DATA_W-1])  ? twos_neg(divisor_q)  : divisor_q;
          neg_quot_q <= op_signed && (dividend_q[DATA_W-1] ^ divisor_q[DATA_W-1]);
          neg_rem_q  <= op_signed && dividend_q[DATA_W-1];
          quot_q     <= ZeroWord;
          rem_q      <= ZeroWord;
          count_q    <= '0;
        end
        S_CALC: begin
          dividend_q <= {dividend_q[DATA_W-2:0], 1'b0};
          rem_q      <= step_rem;
          quot_q     <= quot_fin;
          count_q    <= count_q + CntW'(1);
        end
        default: ;
      endcase

      // Outputs change only on entry to END
      if (enter_end) begin
        waddr_out_q <= waddr_q;
        if (state_q == S_START)
          result_q <= op_rem ? dividend_q : '1;   // divide by zero
        else
          result_q <= op_rem ? rem_signed : quot_signed;
      end
    end
  end

  assign result_o    = result_q;
  assign reg_waddr_o = waddr_out_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dividend_i = '0, divisor_i = '0;
  logic [2:0]  op_i = '0;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic [31:0] result_o;
  logic        ready_o, busy_o, hold_req_o;
  logic [4:0]  reg_waddr_o;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  ex_div dut (
    .clk(clk), .rst(rst),
    .dividend_i(dividend_i), .divisor_i(divisor_i), .op_i(op_i),
    .start_i(start_i), .reg_waddr_i(reg_waddr_i), .abort_i(abort_i),
    .result_o(result_o), .ready_o(ready_o), .reg_waddr_o(reg_waddr_o),
    .busy_o(busy_o), .hold_req_o(hold_req_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request at edge 0, then watch edges 1..60 for ready_o.
  // Cycle number reported = edges after the start edge + 1.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] waddr, input bit extra_starts,
                        output logic [31:0] res, output logic [4:0] wa, output int cyc);
    cyc = 0; res = 'x; wa = 'x;
    @(negedge clk);
    op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = waddr; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    dividend_i = $urandom; divisor_i = $urandom; reg_waddr_i = ~waddr;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        cyc = k + 1; res = result_o; wa = reg_waddr_o;
        break;
      end
      start_i = extra_starts && (k == 5 || k == 12);
      if (start_i) begin
        op_i = OP_REMU; dividend_i = 32'd77; divisor_i = 32'd10; reg_waddr_i = 5'd3;
      end
    end
    start_i = 1'b0;
    if (cyc == 0) begin
      tests++; fails++;
      $display("FAIL timeout: no ready_o within 60 cycles, required one");
    end else begin
      @(posedge clk); #1;
      check("ready_single_pulse", {31'd0, ready_o}, 32'd0);
      check("busy_after_done", {31'd0, busy_o}, 32'd0);
    end
    $display("[TB] op=%03b a=0x%08h b=0x%08h -> res=0x%08h waddr=%0d cycle=%0d", op, a, b, res, wa, cyc);
  endtask

  logic [31:0] res;
  logic [4:0]  wa;
  int          cyc;
  bit          seen;

  initial begin
    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   34};
    vecs[3]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   34};
    vecs[4]  = '{OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          34};
    vecs[5]  = '{OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   2};
    vecs[6]  = '{OP_REM,  32'd5,          32'd0,          32'd5,          2};
    vecs[7]  = '{OP_DIVU, 32'd0,          32'd0,          32'hFFFFFFFF,   2};
    vecs[8]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   34};
    vecs[9]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          34};
    vecs[10] = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          34};
    vecs[11] = '{OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   34};
    vecs[12] = '{OP_DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   34};
    vecs[13] = '{OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   34};
    vecs[14] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   34};
    vecs[15] = '{OP_REMU, 32'hFFFFFFFF,   32'h10,         32'hF,          34};

    // Reset state
    #2;
    check("rst_result", result_o, 32'd0);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_hold", {31'd0, hold_req_o}, 32'd0);
    check("rst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b0, res, wa, cyc);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_cycle", i), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_waddr", i), {27'd0, wa}, 32'(i + 1));
    end

    // Abort in cycle 10 of CALC
    @(negedge clk);
    op_i = OP_DIVU; dividend_i = 32'd100; divisor_i = 32'd7; reg_waddr_i = 5'd9; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin @(posedge clk); #1; end
    check("abort_hold_before", {31'd0, hold_req_o}, 32'd1);
    abort_i = 1'b1;
    @(posedge clk); #1; abort_i = 1'b0;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_hold", {31'd0, hold_req_o}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (ready_o) seen = 1'b1; end
    check("abort_no_ready", {31'd0, seen}, 32'd0);
    check("abort_result_kept", result_o, 32'hF);
    $display("[TB] abort in CALC: busy=%0d hold=%0d ready_seen=%0d", busy_o, hold_req_o, seen);
    run_op(OP_DIVU, 32'd50, 32'd5, 5'd21, 1'b0, res, wa, cyc);
    check("post_abort_result", res, 32'd10);
    check("post_abort_cycle", 32'(cyc), 32'd34);

    // Extra start pulses during CALC ignored
    run_op(OP_DIVU, 32'd1000, 32'd3, 5'd12, 1'b1, res, wa, cyc);
    check("extra_start_result", res, 32'd333);
    check("extra_start_waddr", {27'd0, wa}, 32'd12);
    check("extra_start_cycle", 32'(cyc), 32'd34);

    // Reset mid-CALC
    @(negedge clk);
    op_i = OP_DIV; dividend_i = 32'd900; divisor_i = 32'd30; reg_waddr_i = 5'd7; start_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    for (int k = 1; k <= 8; k++) begin @(posedge clk); #1; end
    rst = 1'b0; #1;
    check("midrst_result", result_o, 32'd0);
    check("midrst_waddr", {27'd0, reg_waddr_o}, 32'd0);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_hold", {31'd0, hold_req_o}, 32'd0);
    check("midrst_ready", {31'd0, ready_o}, 32'd0);
    $display("[TB] reset mid-CALC: result=0x%08h busy=%0d hold=%0d", result_o, busy_o, hold_req_o);
    @(negedge clk); rst = 1'b1;
    run_op(OP_REMU, 32'd50, 32'd7, 5'd30, 1'b0, res, wa, cyc);
    check("post_rst_result", res, 32'd1);
    check("post_rst_waddr", {27'd0, wa}, 32'd30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
